// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - 8-phase fetch/execute sequencer and control-strobe decode for the accumulator CPU.
// Optional single-step gating of INST_ADDR when CTRL_SINGLE_STEP_EN is defined.
module cpu_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  localparam logic [3:0] S_INST_ADDR  = 4'd0;
  localparam logic [3:0] S_INST_FETCH = 4'd1;
  localparam logic [3:0] S_INST_LOAD  = 4'd2;
  localparam logic [3:0] S_IDLE       = 4'd3;
  localparam logic [3:0] S_OP_ADDR    = 4'd4;
  localparam logic [3:0] S_OP_FETCH   = 4'd5;
  localparam logic [3:0] S_ALU_OP     = 4'd6;
  localparam logic [3:0] S_STORE      = 4'd7;
  localparam logic [3:0] S_HALTED     = 4'd8;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  logic [3:0] state_q, state_d;
  logic       is_hlt, is_skz, is_sto, is_jmp, is_aluop;
  logic       start_ok;

  assign is_hlt   = (opcode == OP_HLT);
  assign is_skz   = (opcode == OP_SKZ);
  assign is_sto   = (opcode == OP_STO);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

`ifdef CTRL_SINGLE_STEP_EN
  assign start_ok = step;
`else
  assign start_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INST_ADDR:  if (start_ok) state_d = S_INST_FETCH;
      S_INST_FETCH: if (mem_ready) state_d = S_INST_LOAD;
      S_INST_LOAD:  state_d = S_IDLE;
      S_IDLE:       state_d = S_OP_ADDR;
      S_OP_ADDR:    state_d = is_hlt ? S_HALTED : S_OP_FETCH;
      // Only operand reads wait on memory; SKZ/STO/JMP never stall here.
      S_OP_FETCH:   if (mem_ready || !is_aluop) state_d = S_ALU_OP;
      S_ALU_OP:     state_d = S_STORE;
      S_STORE:      state_d = S_INST_ADDR;
      S_HALTED:     state_d = S_HALTED;
      default:      state_d = S_INST_ADDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_INST_ADDR;
    else       state_q <= state_d;
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    case (state_q)
      S_INST_ADDR: sel = 1'b1;
      S_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      S_INST_LOAD, S_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      S_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = is_hlt;
      end
      S_OP_FETCH: rd = is_aluop;
      S_ALU_OP: begin
        rd     = is_aluop;
        inc_pc = is_skz && zero;
        ld_pc  = is_jmp;
        data_e = is_sto;
      end
      S_STORE: begin
        rd     = is_aluop;
        ld_ac  = is_aluop;
        ld_pc  = is_jmp;
        wr     = is_sto;
        data_e = is_sto;
      end
      S_HALTED: halt = 1'b1;
      default: ;
    endcase
  end

  assign phase = (state_q == S_HALTED) ? 3'd4 : state_q[2:0];

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed-vector bench for cpu_controller.
// Strobe vector bit order: {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ready;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step;
`endif
  logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
  logic [2:0] phase;
  logic [8:0] vec;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [8:0] V_P0   = 9'b100000000;
  localparam logic [8:0] V_P1   = 9'b110000000;
  localparam logic [8:0] V_P23  = 9'b110100000;
  localparam logic [8:0] V_P4   = 9'b000000100;
  localparam logic [8:0] V_NONE = 9'b000000000;
  localparam logic [8:0] V_RD   = 9'b010000000;
  localparam logic [8:0] V_RDAC = 9'b010010000;
  localparam logic [8:0] V_LDPC = 9'b000001000;
  localparam logic [8:0] V_DE   = 9'b000000010;
  localparam logic [8:0] V_WRDE = 9'b001000010;
  localparam logic [8:0] V_HLT4 = 9'b000000101;
  localparam logic [8:0] V_HALT = 9'b000000001;

  cpu_controller dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
`ifdef CTRL_SINGLE_STEP_EN
    .step      (step),
`endif
    .sel       (sel),
    .rd        (rd),
    .wr        (wr),
    .ld_ir     (ld_ir),
    .ld_ac     (ld_ac),
    .ld_pc     (ld_pc),
    .inc_pc    (inc_pc),
    .data_e    (data_e),
    .halt      (halt),
    .phase     (phase)
  );

  assign vec = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one instruction from phase 0; opcode is inverted in phases 0-2 to show it is ignored there.
  task automatic run_instr(input logic [2:0] op, input logic z, input logic mr_low_exec,
                           input string name, input logic [8:0] ev [8]);
    zero = z;
    for (int i = 0; i < 8; i++) begin
      opcode    = (i < 3) ? ~op : op;
      mem_ready = (mr_low_exec && i >= 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      check($sformatf("%s_phase%0d", name, i), 32'(phase), i);
      check($sformatf("%s_strobes%0d", name, i), 32'(vec), 32'(ev[i]));
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    check($sformatf("%s_wrap", name), 32'(phase), 0);
  endtask

  logic [8:0] ev [8];

  initial begin
    reset     = 1'b1;
    opcode    = 3'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
    step      = 1'b1;
`endif
    #3;
    check("reset_phase", 32'(phase), 0);
    check("reset_strobes", 32'(vec), 32'(V_P0));
    @(posedge clk);
    #1 reset = 1'b0;

    ev = '{V_P0, V_P1, V_P23, V_P23, V_P4, V_RD, V_RD, V_RDAC};
    run_instr(3'd2, 1'b0, 1'b0, "add", ev);
    ev = '{V_P0, V_P1, V_P23, V_P23, V_P4, V_NONE, V_P4, V_NONE};
    run_instr(3'd1, 1'b1, 1'b0, "skz_z1", ev);
    ev = '{V_P0, V_P1, V_P23, V_P23, V_P4, V_NONE, V_NONE, V_NONE};
    run_instr(3'd1, 1'b0, 1'b0, "skz_z0", ev);
    ev = '{V_P0, V_P1, V_P23, V_P23, V_P4, V_NONE, V_LDPC, V_LDPC};
    run_instr(3'd7, 1'b0, 1'b0, "jmp", ev);
    ev = '{V_P0, V_P1, V_P23, V_P23, V_P4, V_NONE, V_DE, V_WRDE};
    run_instr(3'd6, 1'b0, 1'b1, "sto_nostall", ev);

    opcode    = 3'd2;
    mem_ready = 1'b0;
    adv(1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("ifetch_stall_phase%0d", k), 32'(phase), 1);
      check($sformatf("ifetch_stall_rd%0d", k), 32'(rd), 1);
      @(posedge clk);
      #1;
      if (k == 2) mem_ready = 1'b1;
    end
    check("ifetch_stall_exit", 32'(phase), 2);
    adv(6);
    check("ifetch_stall_wrap", 32'(phase), 0);

    opcode = 3'd5;
    adv(5);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("lda_stall_phase%0d", k), 32'(phase), 5);
      check($sformatf("lda_stall_rd%0d", k), 32'(rd), 1);
      @(posedge clk);
      #1;
      if (k == 1) mem_ready = 1'b1;
    end
    check("lda_stall_exit", 32'(phase), 6);
    adv(2);
    check("lda_stall_wrap", 32'(phase), 0);

    opcode = 3'd2;
    adv(5);
    mem_ready = 1'b0;
    adv(2);
    check("pre_reset_stalled", 32'(phase), 5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_phase", 32'(phase), 0);
    check("async_reset_strobes", 32'(vec), 32'(V_P0));
    @(posedge clk);
    #1 reset = 1'b0;
    mem_ready = 1'b1;

    ev = '{V_P0, V_P1, V_P23, V_P23, V_HLT4, V_NONE, V_NONE, V_NONE};
    for (int i = 0; i < 5; i++) begin
      opcode = (i < 3) ? 3'd7 : 3'd0;
      @(negedge clk);
      check($sformatf("hlt_phase%0d", i), 32'(phase), i);
      check($sformatf("hlt_strobes%0d", i), 32'(vec), 32'(ev[i]));
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 20; k++) begin
      opcode = 3'(k);
      zero   = k[0];
      @(negedge clk);
      check($sformatf("halted_phase%0d", k), 32'(phase), 4);
      check($sformatf("halted_strobes%0d", k), 32'(vec), 32'(V_HALT));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    check("halt_reset_phase", 32'(phase), 0);
    check("halt_reset_strobes", 32'(vec), 32'(V_P0));
    @(posedge clk);
    #1 reset = 1'b0;
    ev = '{V_P0, V_P1, V_P23, V_P23, V_P4, V_RD, V_RD, V_RDAC};
    run_instr(3'd4, 1'b0, 1'b0, "xor_after_halt", ev);

`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("step_wait%0d", k), 32'(phase), 0);
      check($sformatf("step_wait_strobes%0d", k), 32'(vec), 32'(V_P0));
      @(posedge clk);
      #1;
    end
    step = 1'b1;
    adv(1);
    step = 1'b0;
    check("step_go", 32'(phase), 1);
    adv(7);
    check("step_done", 32'(phase), 0);
    adv(3);
    check("step_rewait", 32'(phase), 0);
    step = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
